// File: rtl/midi_voice_phase_gen_pkg.sv
// midi_phase_pkg: FSM state type and top-octave (C9..B9) DDS table constants.
package midi_phase_pkg;

    typedef enum logic [1:0] {IDLE, DIV, CALC} state_t;

    // C9..B9 in milli-Hz, 12-TET anchored on A9 = 14080 Hz
    localparam logic [63:0] F9_MHZ [12] = '{
        64'd8372018,  64'd8869844,  64'd9397273,  64'd9956063,
        64'd10548082, 64'd11175303, 64'd11839822, 64'd12543854,
        64'd13289750, 64'd14080000, 64'd14917240, 64'd15804266
    };

    function automatic logic [63:0] table_entry(input logic [3:0] s, input int acc_w,
                                                input int frac, input int clk_hz);
        logic [63:0] w_den;
        if (s > 4'd11) return 64'd0;
        w_den = 64'(clk_hz) * 64'd1000;
        return (F9_MHZ[s] * (64'd1 << (acc_w + frac)) + w_den / 64'd2) / w_den;
    endfunction

endpackage

// File: rtl/midi_voice_phase_gen_voice_glide.sv
// voice_glide: one voice's current/target phase increment and gate;
// steps current toward target on glide ticks without overshoot.
module voice_glide #(
    parameter int ACC_WIDTH   = 24,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Load,
    input  logic                 i_Set_Tgt,
    input  logic                 i_Off,
    input  logic                 i_Tick,
    input  logic [ACC_WIDTH-1:0] i_Tgt,
    output logic [ACC_WIDTH-1:0] o_Cur,
    output logic                 o_Active
);

    logic [ACC_WIDTH-1:0] r_cur, r_tgt, w_diff, w_sh, w_step;
    logic                 r_active, w_up;

    assign w_up   = r_cur < r_tgt;
    assign w_diff = w_up ? r_tgt - r_cur : r_cur - r_tgt;
    assign w_sh   = w_diff >> GLIDE_SHIFT;
    // step is at least 1 and never exceeds the remaining distance
    assign w_step = (w_sh == '0) ? ACC_WIDTH'(1) : w_sh;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_cur    <= '0;
            r_tgt    <= '0;
            r_active <= 1'b0;
        end else if (i_Off) begin
            r_cur    <= '0;
            r_tgt    <= '0;
            r_active <= 1'b0;
        end else if (i_Set_Tgt) begin
            r_tgt    <= i_Tgt;
            r_active <= 1'b1;
            if (i_Load) r_cur <= i_Tgt;
        end else if (i_Tick && r_active && GLIDE_SHIFT != 0 && r_cur != r_tgt) begin
            r_cur <= w_up ? r_cur + w_step : r_cur - w_step;
        end
    end

    assign o_Cur    = r_cur;
    assign o_Active = r_active;

endmodule

// File: rtl/midi_voice_phase_gen.sv
// midi_voice_phase_gen: MIDI note-on/off commands to per-voice DDS phase increments,
// using an iterative octave divider, a shifted top-octave table and optional glide.
module midi_voice_phase_gen
    import midi_phase_pkg::*;
#(
    parameter  int ACC_WIDTH   = 24,
    parameter  int CLK_HZ      = 25_000_000,
    parameter  int NUM_VOICES  = 4,
    parameter  int TABLE_FRAC  = 12,
    parameter  int GLIDE_DIV   = 25_000,
    parameter  int GLIDE_SHIFT = 4,
    localparam int VW          = $clog2(NUM_VOICES > 2 ? NUM_VOICES : 2)
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
    input  logic                            i_Cmd_Valid,
    output logic                            o_Cmd_Ready,
    input  logic                            i_Cmd_Off,
    input  logic [VW-1:0]                   i_Cmd_Voice,
    input  logic [6:0]                      i_Cmd_Note,
    output logic [NUM_VOICES*ACC_WIDTH-1:0] o_Phase_Inc,
    output logic [NUM_VOICES-1:0]           o_Active
);

    localparam int TW = ACC_WIDTH + TABLE_FRAC;
    localparam int CW = $clog2(GLIDE_DIV > 2 ? GLIDE_DIV : 2);

    state_t                r_state, w_state_nx;
    logic [6:0]            r_rem;
    logic [3:0]            r_oct;
    logic [VW-1:0]         r_voice;
    logic                  r_off_pend;
    logic [CW-1:0]         r_cnt;
    logic                  w_accept, w_voice_ok, w_tick, w_wr;
    logic [5:0]            w_k;
    logic [TW:0]           w_round, w_sum;
    logic [ACC_WIDTH-1:0]  w_inc;
    logic [TW-1:0]         w_table [16];
    logic [ACC_WIDTH-1:0]  w_cur [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_act;

    assign o_Cmd_Ready = (r_state == IDLE);
    assign w_accept    = i_Cmd_Valid && o_Cmd_Ready;
    assign w_voice_ok  = {1'b0, i_Cmd_Voice} < (VW+1)'(NUM_VOICES);
    assign w_tick      = (r_cnt == CW'(GLIDE_DIV - 1));
    assign w_wr        = (r_state == CALC);

    // octave o scales the top-octave entry down by (10-o) octaves, rounded half up
    assign w_k     = 6'(TABLE_FRAC) + 6'(4'd10 - r_oct);
    assign w_round = (w_k == 6'd0) ? '0 : ((TW+1)'(1) << (w_k - 6'd1));
    assign w_sum   = {1'b0, w_table[r_rem[3:0]]} + w_round;
    assign w_inc   = ACC_WIDTH'(w_sum >> w_k);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept && !i_Cmd_Off && w_voice_ok) w_state_nx = DIV;
            DIV:     if (r_rem < 7'd12) w_state_nx = CALC;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_oct      <= '0;
            r_voice    <= '0;
            r_off_pend <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
            r_off_pend <= w_accept && i_Cmd_Off && w_voice_ok;
            if (w_accept) begin
                r_rem   <= i_Cmd_Note;
                r_oct   <= '0;
                r_voice <= i_Cmd_Voice;
            end else if (r_state == DIV && r_rem >= 7'd12) begin
                r_rem <= r_rem - 7'd12;
                r_oct <= r_oct + 4'd1;
            end
        end
    end

    for (genvar s = 0; s < 16; s++) begin : g_tab
        localparam logic [TW-1:0] E = TW'(table_entry(4'(s), ACC_WIDTH, TABLE_FRAC, CLK_HZ));
        assign w_table[s] = E;
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic w_sel;
        assign w_sel = w_wr && (r_voice == VW'(v));
        voice_glide #(
            .ACC_WIDTH   (ACC_WIDTH),
            .GLIDE_SHIFT (GLIDE_SHIFT)
        ) u_voice (
            .i_Clk     (i_Clk),
            .i_Rst_L   (i_Rst_L),
            .i_Load    (w_sel && (GLIDE_SHIFT == 0 || !w_act[v])),
            .i_Set_Tgt (w_sel),
            .i_Off     (r_off_pend && (r_voice == VW'(v))),
            .i_Tick    (w_tick),
            .i_Tgt     (w_inc),
            .o_Cur     (w_cur[v]),
            .o_Active  (w_act[v])
        );
        assign o_Phase_Inc[v*ACC_WIDTH +: ACC_WIDTH] = w_cur[v];
    end

    assign o_Active = w_act;

endmodule

// File: tb/tb_midi_voice_phase_gen.sv
// tb_midi_voice_phase_gen: directed vectors against a no-glide instance (3 voices)
// and a fast-glide instance (4 voices) sharing one command stream.
module tb_midi_voice_phase_gen;

    localparam int AW = 24;

    typedef struct {
        logic        off;
        logic [1:0]  voice;
        logic [6:0]  note;
        logic [23:0] exp_inc;
        int          lat;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0, valid = 1'b0, off = 1'b0;
    logic [1:0]    voice = '0;
    logic [6:0]    note = '0;
    logic          rdy0, rdy1;
    logic [3*AW-1:0] inc0;
    logic [4*AW-1:0] inc1;
    logic [2:0]    act0;
    logic [3:0]    act1;
    int            n_cmp = 0, n_bad = 0;
    vec_t          vecs [8];
    logic [23:0]   m_inc [3];
    logic [2:0]    m_act;

    always #5 clk = ~clk;

    midi_voice_phase_gen #(.NUM_VOICES(3), .GLIDE_SHIFT(0)) u_dut0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Cmd_Valid(valid), .o_Cmd_Ready(rdy0),
        .i_Cmd_Off(off), .i_Cmd_Voice(voice), .i_Cmd_Note(note),
        .o_Phase_Inc(inc0), .o_Active(act0)
    );

    midi_voice_phase_gen #(.NUM_VOICES(4), .GLIDE_SHIFT(4), .GLIDE_DIV(4)) u_dut1 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Cmd_Valid(valid), .o_Cmd_Ready(rdy1),
        .i_Cmd_Off(off), .i_Cmd_Voice(voice), .i_Cmd_Note(note),
        .o_Phase_Inc(inc1), .o_Active(act1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic o, input logic [1:0] v, input logic [6:0] n);
        for (int w = 0; w < 50 && !(rdy0 && rdy1); w++) tick();
        if (!(rdy0 && rdy1)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_wait: got %0d%0d, expected 11", rdy0, rdy1);
        end
        valid = 1'b1;
        off   = o;
        voice = v;
        note  = n;
        tick();
        valid = 1'b0;
        off   = 1'b0;
    endtask

    function automatic logic [23:0] glide_next(input logic [23:0] c, input logic [23:0] t);
        logic [23:0] d, s;
        d = (c < t) ? t - c : c - t;
        s = d >> 4;
        if (s == 24'd0) s = 24'd1;
        return (c < t) ? c + s : c - s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] prev, cur, exp;
        int last;
        bit first, found;

        vecs = '{
            '{1'b0, 2'd0, 7'd69,  24'd295,  7},
            '{1'b0, 2'd1, 7'd0,   24'd5,    2},
            '{1'b0, 2'd1, 7'd60,  24'd176,  7},
            '{1'b0, 2'd1, 7'd127, 24'd8418, 12},
            '{1'b1, 2'd1, 7'd0,   24'd0,    1},
            '{1'b0, 2'd0, 7'd11,  24'd10,   2},
            '{1'b0, 2'd0, 7'd12,  24'd11,   3},
            '{1'b1, 2'd0, 7'd0,   24'd0,    1}
        };
        m_inc = '{24'd0, 24'd0, 24'd0};
        m_act = '0;

        tick();
        check("rst_inc0", inc0, 0);
        check("rst_act0", act0, 0);
        check("rst_rdy0", rdy0, 1);
        check("rst_inc1", inc1[95:64] == 0 && inc1[63:0] == 0, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_rst_rdy", {rdy0, rdy1}, 2'b11);
        check("post_rst_act", {act0, act1}, 0);

        // latency, ready and table values on the no-glide instance
        for (int i = 0; i < 8; i++) begin
            int v;
            v = int'(vecs[i].voice);
            send(vecs[i].off, vecs[i].voice, vecs[i].note);
            for (int n = 0; n <= vecs[i].lat; n++) begin
                if (n > 0) tick();
                if (n < vecs[i].lat) begin
                    check($sformatf("hold_v%0d_n%0d", i, n), inc0[v*AW +: AW], m_inc[v]);
                    check($sformatf("rdy_busy_v%0d_n%0d", i, n), rdy0, vecs[i].off);
                end else begin
                    check($sformatf("inc_v%0d", i), inc0[v*AW +: AW], vecs[i].exp_inc);
                    check($sformatf("act_v%0d", i), act0[v], !vecs[i].off);
                    check($sformatf("rdy_done_v%0d", i), rdy0, 1);
                end
            end
            m_inc[v] = vecs[i].exp_inc;
            m_act[v] = !vecs[i].off;
        end

        // valid held through a busy note-on with changing fields: single accept
        valid = 1'b1; off = 1'b0; voice = 2'd0; note = 7'd60;
        tick();
        note = 7'd127;
        for (int n = 1; n <= 7; n++) tick();
        valid = 1'b0;
        check("busy_inc", inc0[0 +: AW], 176);
        for (int n = 0; n < 14; n++) tick();
        check("busy_inc_late", inc0[0 +: AW], 176);
        check("busy_rdy_late", rdy0, 1);
        m_inc[0] = 24'd176;
        m_act[0] = 1'b1;

        // voice 3 is out of range for the 3-voice instance
        send(1'b0, 2'd3, 7'd60);
        check("disc_rdy", rdy0, 1);
        for (int n = 0; n < 14; n++) tick();
        check("disc_inc0", inc0, {m_inc[2], m_inc[1], m_inc[0]});
        check("disc_act0", act0, m_act);
        check("v3_inc1", inc1[3*AW +: AW], 176);
        check("v3_act1", act1[3], 1);

        // legato glide 148 -> 295 on voice 2 of the glide instance
        send(1'b0, 2'd2, 7'd57);
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 5) check("g57_before", inc1[2*AW +: AW], 0);
        end
        check("g57_inc", inc1[2*AW +: AW], 148);
        send(1'b0, 2'd2, 7'd69);
        for (int n = 1; n <= 7; n++) tick();
        check("g69_cur_held", inc1[2*AW +: AW], 148);
        check("g69_act", act1[2], 1);
        prev = 24'd148; last = -1; first = 1'b1;
        for (int c = 0; c < 600 && prev != 24'd295; c++) begin
            tick();
            cur = inc1[2*AW +: AW];
            if (cur != prev) begin
                exp = glide_next(prev, 24'd295);
                check($sformatf("glide_val_%0d", c), cur, exp);
                if (first) check("glide_first_step", cur - 24'd148, 9);
                if (last >= 0) check($sformatf("glide_period_%0d", c), c - last, 4);
                first = 1'b0; last = c; prev = cur;
            end
        end
        check("glide_end", prev, 295);
        for (int n = 0; n < 8; n++) tick();
        check("glide_settled", inc1[2*AW +: AW], 295);

        // glide down, then note-off landing on a tick edge
        send(1'b0, 2'd2, 7'd57);
        for (int n = 1; n <= 6; n++) tick();
        prev = inc1[2*AW +: AW];
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            tick();
            found = (inc1[2*AW +: AW] != prev);
        end
        check("down_found", found, 1);
        check("down_first", inc1[2*AW +: AW], 286);
        for (int n = 0; n < 6; n++) tick();
        valid = 1'b1; off = 1'b1; voice = 2'd2; note = 7'd0;
        tick();
        valid = 1'b0; off = 1'b0;
        check("pre_off_cur", inc1[2*AW +: AW], 278);
        check("pre_off_act", act1[2], 1);
        tick();
        check("off_cur", inc1[2*AW +: AW], 0);
        check("off_act", act1[2], 0);
        check("off_other_inc", inc1[3*AW +: AW], 176);
        check("off_other_act", act1[3], 1);
        for (int n = 0; n < 8; n++) tick();
        check("off_cur_late", inc1[2*AW +: AW], 0);

        // asynchronous reset in the middle of DIV
        send(1'b0, 2'd0, 7'd127);
        for (int n = 0; n < 3; n++) tick();
        rst_n = 1'b0;
        #1;
        check("arst_inc0", inc0, 0);
        check("arst_act", {act0, act1}, 0);
        check("arst_inc1", inc1[95:64] == 0 && inc1[63:0] == 0, 1);
        check("arst_rdy", {rdy0, rdy1}, 2'b11);
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < 15; n++) tick();
        check("arst_after_inc0", inc0, 0);
        check("arst_after_act0", act0, 0);
        check("arst_after_rdy", rdy0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
